fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction fetch front end sitting directly upstream of the single-cycle smips datapath.
- Replaces the bare program-counter-to-ROM path with a pipelined fetch engine. It issues in-order requests to a latency-tolerant instruction memory and buffers the returned instructions, with their PCs, in a small FIFO.
- Presents one instruction per cycle to the decode/execute stage with a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes the buffer and discards in-flight responses.

Parameters:
- DEPTH, 4, FIFO entries and maximum in-flight plus buffered instructions (power of two, ≥2).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- redirect_valid  in  1  pulse: flush and restart fetch at redirect_target
- redirect_target  in  32  new fetch PC (word aligned; bits [1:0] ignored, treated as 0)
- imem_req  out  1  request valid
- imem_addr  out  32  request address
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response valid (responses return in request order, ≥1 cycle after accept)
- imem_rdata  in  32  response instruction word
- out_valid  out  1  out_instruction/out_pc valid
- out_ready  in  1  consumer accepts this cycle
- out_instruction  out  32  head instruction
- out_pc  out  32  PC of head instruction

Behaviour:
- State:
  - fetch_pc (32): next request address.
  - resp_pc (32): PC of the next non-discarded response.
  - inflight (clog2(DEPTH+1) bits): accepted requests with no response yet, including those to be discarded.
  - discard (same width): responses still to drop.
  - FIFO of DEPTH {pc, instr} entries with count.
- Reset (reset=0, async):
  - fetch_pc=resp_pc=RESET_PC; inflight=discard=0; FIFO empty.
  - out_valid=0, out_instruction=0, out_pc=0, imem_req=0 while asserted.
  - imem_addr follows fetch_pc, so it reads RESET_PC during reset.
- imem_req = !redirect_valid && (count + inflight < DEPTH), combinational. imem_addr = fetch_pc.
- Accept (imem_req && imem_ready): fetch_pc += 4 (wraps mod 2^32); inflight++.
- Response (imem_rvalid && inflight>0): inflight--.
  - If discard>0: drop it; discard--.
  - Else: push {resp_pc, imem_rdata}; resp_pc += 4.
  - Pushed entry is visible at the output the next cycle (1-cycle rvalid→out_valid latency).
- imem_rvalid with inflight==0 is ignored, nothing pushed (simulation assertion flags it).
- Accept and response in the same cycle: inflight unchanged.
- Output: out_valid = count>0. out_instruction/out_pc = head entry, or 0 when empty.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Credit rule guarantees no push when full. Pop of an empty FIFO cannot occur.
- Redirect cycle (redirect_valid=1), redirect has priority over everything else:
  - No request is issued.
  - The output handshake in this cycle is void: no pop counted, and the consumer must drop it.
  - Any response arriving this cycle is dropped.
  - Next-cycle state: FIFO empty; fetch_pc=resp_pc=target; discard = inflight − (imem_rvalid ? 1 : 0); inflight updated the same way.
  - Fetch restarts at the target the cycle after the redirect.
- Back-to-back redirects: the last one wins; discard is recomputed each time.
- imem_ready low: imem_req held high, imem_addr held stable (no change of request without a redirect).

Test Plan:
- Reset then release, memory with 1-cycle latency, always ready, out_ready=1:
  - imem_addr sequence 0,4,8,…
  - First out_valid 2 cycles after the first accept, with out_pc=0.
  - Steady state: one instruction per cycle, with out_pc incrementing by 4.
- out_ready=0, DEPTH=4: exactly 4 accepts (addrs 0..C), then imem_req=0.
  - out_pc stays 0 and out_instruction stays equal to word@0.
  - Raising out_ready resumes fetch at 0x10 after the first pop.
- 3-cycle memory latency with 2 requests in flight, redirect to 0x100:
  - The 2 stale responses are dropped.
  - The next out_pc is 0x100, and no stale PC ever appears on the output.
- Redirect coincident with imem_rvalid and out_valid&&out_ready:
  - The response is dropped and the FIFO is empty next cycle.
  - discard equals the remaining inflight count.
  - The first new request is addr=target.
- imem_ready low for 5 cycles: imem_req stays 1 and imem_addr stays constant. No state change.
- Assert reset mid-stream with FIFO holding 3 entries and 1 request in flight:
  - Outputs go to zero immediately.
  - After release, fetch restarts at RESET_PC with the FIFO empty.

Source files
------------

// File: rtl/fetch_queue.sv
// Pipelined instruction fetch front end: issues in-order memory requests, buffers
// returned instructions with their PCs and hands them to decode over valid/ready.

module fetch_queue_chk #(
    parameter int unsigned CW = 3
) (
    input logic          clk,
    input logic          reset,
    input logic          imem_rvalid,
    input logic [CW-1:0] inflight_i
);
    // A response with nothing outstanding means the memory broke the protocol
    assert property (@(posedge clk) disable iff (!reset)
        !(imem_rvalid && (inflight_i == {CW{1'b0}})))
        else $error("fetch_queue: imem_rvalid with no request in flight");
endmodule

module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [CW:0]   DEPTH_W  = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   pc_mem_q  [DEPTH];
    logic [31:0]   ins_mem_q [DEPTH];

    logic [CW:0]   credit_s;
    logic          accept_s, resp_s, push_s, pop_s;
    logic [31:0]   target_s;
    logic          unused_target_s;

    // Target low bits are forced to zero, so they are deliberately unused
    assign unused_target_s = ^redirect_target[1:0];
    assign target_s        = {redirect_target[31:2], 2'b00};

    // Buffered plus outstanding instructions may never exceed the FIFO size
    assign credit_s  = {1'b0, count_q} + {1'b0, inflight_q};
    assign imem_req  = reset && !redirect_valid && (credit_s < DEPTH_W);
    assign imem_addr = fetch_pc_q;
    assign accept_s  = imem_req && imem_ready;
    assign resp_s    = imem_rvalid && (inflight_q != CNT_ZERO);
    assign push_s    = resp_s && !redirect_valid && (discard_q == CNT_ZERO);
    assign pop_s     = out_valid && out_ready && !redirect_valid;

    assign out_valid       = (count_q != CNT_ZERO);
    assign out_instruction = out_valid ? ins_mem_q[rd_ptr_q] : 32'h0000_0000;
    assign out_pc          = out_valid ? pc_mem_q[rd_ptr_q]  : 32'h0000_0000;

    // Next-state computation; a redirect overrides every other update
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (redirect_valid) begin
            fetch_pc_d = target_s;
            resp_pc_d  = target_s;
            if (resp_s) begin
                inflight_d = inflight_q - CNT_ONE;
            end else begin
                inflight_d = inflight_q;
            end
            discard_d = inflight_d;
            count_d   = CNT_ZERO;
            rd_ptr_d  = PTR_ZERO;
            wr_ptr_d  = PTR_ZERO;
        end else begin
            if (accept_s) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            case ({accept_s, resp_s})
                2'b10:   inflight_d = inflight_q + CNT_ONE;
                2'b01:   inflight_d = inflight_q - CNT_ONE;
                default: inflight_d = inflight_q;
            endcase
            if (resp_s && (discard_q != CNT_ZERO)) begin
                discard_d = discard_q - CNT_ONE;
            end else begin
                discard_d = discard_q;
            end
            if (push_s) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wr_ptr_d  = wr_ptr_q + PTR_ONE;
            end else begin
                resp_pc_d = resp_pc_q;
                wr_ptr_d  = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= CNT_ZERO;
            discard_q  <= CNT_ZERO;
            count_q    <= CNT_ZERO;
            rd_ptr_q   <= PTR_ZERO;
            wr_ptr_q   <= PTR_ZERO;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Entry storage; contents are only observed while count is non-zero
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_q[wr_ptr_q]  <= resp_pc_q;
            ins_mem_q[wr_ptr_q] <= imem_rdata;
        end
    end

    fetch_queue_chk #(.CW(CW)) u_chk (
        .clk         (clk),
        .reset       (reset),
        .imem_rvalid (imem_rvalid),
        .inflight_i  (inflight_q)
    );
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order memory model of selectable latency.

module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;

    int          passed = 0;
    int          total  = 0;
    int          lat    = 1;
    int          cyc_q  = 0;
    int          acc_cnt = 0;
    logic [31:0] q_addr [$];
    int          q_due  [$];

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc)
    );

    always #5 clk = ~clk;

    // Memory: word at address a is A000_0000 + a, returned lat cycles after accept
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_addr.delete();
            q_due.delete();
            imem_rvalid <= 1'b0;
            imem_rdata  <= 32'h0;
            cyc_q       <= 0;
            acc_cnt     <= 0;
        end else begin
            if (imem_req && imem_ready) begin
                q_addr.push_back(imem_addr);
                q_due.push_back(cyc_q + lat);
                acc_cnt <= acc_cnt + 1;
            end
            if (q_due.size() > 0 && q_due[0] == cyc_q + 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= 32'hA000_0000 + q_addr[0];
                q_addr.delete(0);
                q_due.delete(0);
            end else begin
                imem_rvalid <= 1'b0;
                imem_rdata  <= 32'h0;
            end
            cyc_q <= cyc_q + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    // Leaves the bench 3 time units into cycle 0 after reset release
    task automatic do_reset(input int l, input logic ordy);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        imem_ready     = 1'b1;
        out_ready      = ordy;
        lat            = l;
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        #1 reset = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instruction, 32'h0);
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);

        // Streaming, latency 1
        do_reset(1, 1'b1);
        chk("s_req0", 32'(imem_req), 32'h1);
        chk("s_addr0", imem_addr, 32'h0);
        tick();
        chk("s_addr1", imem_addr, 32'h4);
        chk("s_valid1", 32'(out_valid), 32'h0);
        tick();
        chk("s_valid2", 32'(out_valid), 32'h1);
        chk("s_pc2", out_pc, 32'h0);
        chk("s_instr2", out_instruction, 32'hA000_0000);
        chk("s_addr2", imem_addr, 32'h8);
        tick();
        chk("s_pc3", out_pc, 32'h4);
        tick();
        chk("s_pc4", out_pc, 32'h8);
        chk("s_instr4", out_instruction, 32'hA000_0008);

        // Consumer stalled: FIFO fills, fetch stops
        do_reset(1, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        chk("f_req", 32'(imem_req), 32'h0);
        chk("f_accepts", 32'(acc_cnt), 32'h4);
        chk("f_valid", 32'(out_valid), 32'h1);
        chk("f_pc", out_pc, 32'h0);
        chk("f_instr", out_instruction, 32'hA000_0000);
        chk("f_addr", imem_addr, 32'h10);
        out_ready = 1'b1;
        tick();
        chk("f_resume_req", 32'(imem_req), 32'h1);
        chk("f_resume_addr", imem_addr, 32'h10);
        chk("f_resume_pc", out_pc, 32'h4);

        // Reset mid-stream with three buffered and one in flight
        do_reset(1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk("m_pre_valid", 32'(out_valid), 32'h1);
        chk("m_pre_req", 32'(imem_req), 32'h0);
        #2 reset = 1'b0;
        #1;
        chk("m_valid", 32'(out_valid), 32'h0);
        chk("m_pc", out_pc, 32'h0);
        chk("m_instr", out_instruction, 32'h0);
        chk("m_req", 32'(imem_req), 32'h0);
        chk("m_addr", imem_addr, 32'h0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("m_rel_req", 32'(imem_req), 32'h1);
        chk("m_rel_addr", imem_addr, 32'h0);
        chk("m_rel_valid", 32'(out_valid), 32'h0);
        tick();
        tick();
        chk("m_rel_pc", out_pc, 32'h0);
        chk("m_rel_valid2", 32'(out_valid), 32'h1);

        // Latency 3, redirect with two requests outstanding
        do_reset(3, 1'b1);
        tick();
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0100;
        #1;
        chk("r_req_redirect", 32'(imem_req), 32'h0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("r_req", 32'(imem_req), 32'h1);
        chk("r_addr", imem_addr, 32'h100);
        chk("r_valid3", 32'(out_valid), 32'h0);
        for (int i = 4; i < 7; i++) begin
            tick();
            chk("r_no_stale", 32'(out_valid), 32'h0);
        end
        tick();
        chk("r_valid7", 32'(out_valid), 32'h1);
        chk("r_pc7", out_pc, 32'h100);
        chk("r_instr7", out_instruction, 32'hA000_0100);

        // Redirect coincident with a response and a pop; low target bits ignored
        do_reset(1, 1'b1);
        tick();
        tick();
        tick();
        chk("c_pre_pc", out_pc, 32'h4);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0203;
        #1;
        chk("c_req_redirect", 32'(imem_req), 32'h0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("c_empty", 32'(out_valid), 32'h0);
        chk("c_req", 32'(imem_req), 32'h1);
        chk("c_addr", imem_addr, 32'h200);
        tick();
        chk("c_valid5", 32'(out_valid), 32'h0);
        chk("c_addr5", imem_addr, 32'h204);
        tick();
        chk("c_valid6", 32'(out_valid), 32'h1);
        chk("c_pc6", out_pc, 32'h200);
        chk("c_instr6", out_instruction, 32'hA000_0200);

        // Memory not ready for five cycles: request held stable
        do_reset(1, 1'b1);
        tick();
        imem_ready = 1'b0;
        #1;
        chk("w_req", 32'(imem_req), 32'h1);
        chk("w_addr", imem_addr, 32'h4);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("w_req_hold", 32'(imem_req), 32'h1);
            chk("w_addr_hold", imem_addr, 32'h4);
        end
        tick();
        imem_ready = 1'b1;
        #1;
        chk("w_addr_go", imem_addr, 32'h4);
        tick();
        chk("w_addr_next", imem_addr, 32'h8);
        tick();
        chk("w_valid8", 32'(out_valid), 32'h1);
        chk("w_pc8", out_pc, 32'h4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
